// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the non-forwarding five-stage pipeline.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
  parameter int unsigned NUM_HAZ_STAGES = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_id_valid,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_id_rs1_used,
  input  logic       i_id_rs2_used,
  input  logic [4:0] i_id_rd,
  input  logic       i_id_regwen,
  input  logic       i_ex_redirect,
  input  logic       i_mem_stall,
  output logic       o_pc_en,
  output logic       o_if_id_stall,
  output logic       o_if_id_flush,
  output logic       o_id_ex_stall,
  output logic       o_id_ex_flush,
  output logic       o_ex_mem_stall,
  output logic       o_raw_hazard,
  output logic [1:0] o_state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] o_stall_cnt,
  output logic [31:0] o_flush_cnt,
  output logic [31:0] o_memwait_cnt
`endif
);

  localparam int unsigned REG_W = 5;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_RAW   = 2'd1,
    ST_REDIR = 2'd2,
    ST_MEMW  = 2'd3
  } state_e;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
  } sb_entry_t;

  sb_entry_t sb_q [NUM_HAZ_STAGES];
  state_e    state_q;
  state_e    state_d;
  logic      sb_hit;

  // RAW match of ID sources against in-flight destinations; x0 never matches
  always_comb begin
    sb_hit = 1'b0;
    for (int i = 0; i < int'(NUM_HAZ_STAGES); i++) begin
      if (sb_q[i].valid &&
          ((i_id_rs1_used && (i_id_rs1 != '0) && (sb_q[i].rd == i_id_rs1)) ||
           (i_id_rs2_used && (i_id_rs2 != '0) && (sb_q[i].rd == i_id_rs2))))
        sb_hit = 1'b1;
    end
  end

  assign o_raw_hazard = !i_rst && i_id_valid && sb_hit;
  assign o_state      = state_q;

  // Action selection in priority order: mem wait, redirect, RAW stall, run
  always_comb begin
    state_d        = ST_RUN;
    o_pc_en        = 1'b1;
    o_if_id_stall  = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_stall  = 1'b0;
    o_id_ex_flush  = 1'b0;
    o_ex_mem_stall = 1'b0;
    if (i_rst) begin
      state_d = ST_RUN;
    end else if (i_mem_stall) begin
      state_d        = ST_MEMW;
      o_pc_en        = 1'b0;
      o_if_id_stall  = 1'b1;
      o_id_ex_stall  = 1'b1;
      o_ex_mem_stall = 1'b1;
    end else if (i_ex_redirect) begin
      state_d       = ST_REDIR;
      o_if_id_flush = 1'b1;
      o_id_ex_flush = 1'b1;
    end else if (o_raw_hazard) begin
      state_d       = ST_RAW;
      o_pc_en       = 1'b0;
      o_if_id_stall = 1'b1;
      o_id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // Scoreboard mirrors EX/MEM/WB; frozen during mem wait, bubble unless RUN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < int'(NUM_HAZ_STAGES); i++) sb_q[i] <= '0;
    end else if (state_d != ST_MEMW) begin
      for (int i = int'(NUM_HAZ_STAGES) - 1; i >= 1; i--) sb_q[i] <= sb_q[i-1];
      sb_q[0].valid <= (state_d == ST_RUN) && i_id_valid && i_id_regwen && (i_id_rd != '0);
      sb_q[0].rd    <= i_id_rd;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_stall_cnt   <= '0;
      o_flush_cnt   <= '0;
      o_memwait_cnt <= '0;
    end else begin
      if (state_d == ST_RAW)   o_stall_cnt   <= o_stall_cnt + 32'd1;
      if (state_d == ST_REDIR) o_flush_cnt   <= o_flush_cnt + 32'd1;
      if (state_d == ST_MEMW)  o_memwait_cnt <= o_memwait_cnt + 32'd1;
    end
  end
`endif

endmodule
